insn_decoder: RTL and testbench
===============================

INSN_DECODER -- requirements
Module: insn_decoder

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 11, operand field width; INSTRUCTION_WIDTH, default 16, instruction word width.
REQ-002 SHALL have port clock_in  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_in  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port op_code  input  INSTRUCTION_WIDTH-DATA_WIDTH+1 (6)  opcode from the instruction register; only [4:0] are decoded, and bit 5 = 1 is decoded as an unused opcode.
REQ-005 SHALL have ports status_Z_in and status_N_in  input  1 each  zero and negative flags from the status register.
REQ-006 SHALL have port branch_out  output  1  PC loads the operand field instead of PC+1.
REQ-007 SHALL have port sel_A_out  output  2  accumulator source: 00 data memory, 01 immediate operand, 10 ALU result, 11 unused.
REQ-008 SHALL have port sel_B_out  output  1  ALU operand B: 0 data memory, 1 immediate.
REQ-009 SHALL have port alu_op_out  output  1  0 add, 1 subtract.
REQ-010 SHALL have ports data_memory_wr_out, acc_wr_out, pc_wr_out, status_wr_out, ir_wr_out  output  1 each  write enables.
REQ-011 SHALL have ports acc_reset_out, pc_reset_out, status_reset_out, ir_reset_out  output  1 each  register clears.

Function
REQ-012 SHALL implement a Moore FSM with two states, FETCH and EXEC, with transitions FETCH->EXEC->FETCH on every rising edge while reset_in = 0.
REQ-013 In FETCH, ir_wr_out SHALL be 1 and every other output 0.
REQ-014 In EXEC, ir_wr_out SHALL be 0, and outputs SHALL decode combinationally from op_code and flags; any output not listed for an opcode is 0.
REQ-015 00000 HLT: all outputs 0, with pc_wr_out = 0, so the same instruction is refetched and the machine stays halted.
REQ-016 00001 STO: data_memory_wr_out = 1, pc_wr_out = 1.
REQ-017 00010 LD: sel_A_out = 00, acc_wr_out = 1, pc_wr_out = 1.
REQ-018 00011 LDI: sel_A_out = 01, acc_wr_out = 1, pc_wr_out = 1.
REQ-019 00100 ADD / 00101 ADDI / 00110 SUB / 00111 SUBI: sel_A_out = 10, acc_wr_out = 1, status_wr_out = 1, pc_wr_out = 1; sel_B_out = 1 for ADDI/SUBI; alu_op_out = 1 for SUB/SUBI.
REQ-020 Branches SHALL drive pc_wr_out = 1, with branch_out = condition: 01000 BEQ Z; 01001 BNE !Z; 01010 BGT !Z&!N; 01011 BGE !N; 01100 BLT N; 01101 BLE Z|N; 01110 JMP 1.
REQ-021 Flag changes during EXEC SHALL propagate to branch_out within the same cycle, with no registering.
REQ-022 Opcodes 01111-11111 and any op_code with bit 5 set SHALL act as NOP: pc_wr_out = 1 and all others 0.

Reset
REQ-023 While reset_in = 1, the FSM SHALL be forced to FETCH asynchronously.
REQ-024 While reset_in = 1, acc/pc/status/ir_reset_out SHALL be 1.
REQ-025 While reset_in = 1, all write enables, branch_out, sel_A_out, sel_B_out and alu_op_out SHALL be 0.
REQ-026 Reset outputs SHALL equal reset_in combinationally and SHALL be 0 otherwise.
REQ-027 After deassertion, the first rising edge SHALL perform FETCH (IR load), and the second SHALL perform EXEC.
REQ-028 Reset asserted in EXEC SHALL abort the instruction immediately, with no write enables asserted.

Structure
REQ-029 A shared package SHALL hold the opcode enumeration (5-bit constants HLT..JMP), the sel_A encodings and the FSM state typedef.
REQ-030 The design SHALL be a single module with no sub-modules.
REQ-031 Bench clock source SHALL be clock_generator, single output, 2 ns period with 50% duty, starting low.

Verification
REQ-032 reset_in = 1 with any op_code -> four *_reset_out = 1 and all other outputs 0; release -> next edge FETCH (ir_wr_out = 1), following edge EXEC.
REQ-033 Sweep 00000..00111 in EXEC -> exact vectors of REQ-015..019, e.g. ADDI gives sel_A_out = 10, sel_B_out = 1, alu_op_out = 0, acc_wr_out = 1, status_wr_out = 1, pc_wr_out = 1.
REQ-034 BEQ/BNE with Z toggled 0->1->0 in EXEC -> branch_out follows Z (BEQ) and !Z (BNE); pc_wr_out = 1 throughout.
REQ-035 BGT/BGE/BLT/BLE over all four (Z,N) combinations -> branch_out per REQ-020, e.g. BGT Z=0 N=0 -> 1, BLE Z=0 N=0 -> 0.
REQ-036 JMP -> branch_out = 1 regardless of flags; HLT -> pc_wr_out = 0 in EXEC across multiple cycles.
REQ-037 Assert reset_in mid-EXEC of STO -> data_memory_wr_out drops to 0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/insn_decoder_pkg.sv
// insn_decoder_pkg
//   Shared definitions for the instruction decoder: the 5-bit opcode
//   enumeration, the accumulator source-select encodings and the FSM
//   state type with its two state constants.
`timescale 1ns/1ps
package insn_decoder_pkg;

  typedef enum logic [4:0] {
    OP_HLT  = 5'b00000,
    OP_STO  = 5'b00001,
    OP_LD   = 5'b00010,
    OP_LDI  = 5'b00011,
    OP_ADD  = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SUBI = 5'b00111,
    OP_BEQ  = 5'b01000,
    OP_BNE  = 5'b01001,
    OP_BGT  = 5'b01010,
    OP_BGE  = 5'b01011,
    OP_BLT  = 5'b01100,
    OP_BLE  = 5'b01101,
    OP_JMP  = 5'b01110
  } opcode_t;

  // Accumulator source select
  localparam logic [1:0] SEL_A_MEM = 2'b00;
  localparam logic [1:0] SEL_A_IMM = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;

  // FSM state type and states
  typedef logic [0:0] state_t;
  localparam state_t ST_FETCH = 1'b0;
  localparam state_t ST_EXEC  = 1'b1;

endpackage

// File: rtl/insn_decoder.sv
// insn_decoder
//   Two-state (FETCH/EXEC) control unit for a small accumulator machine.
//   FETCH loads the instruction register; EXEC decodes op_code and the
//   Z/N status flags combinationally into datapath controls.
// Ports:
//   clock_in            - clock, state advances on rising edge
//   reset_in            - asynchronous active-high reset
//   op_code             - opcode from IR; bit 5 set decodes as NOP
//   status_Z_in/N_in    - zero / negative flags
//   branch_out          - PC loads operand instead of PC+1
//   sel_A_out           - accumulator source (mem / imm / alu)
//   sel_B_out           - ALU operand B (0 mem, 1 imm)
//   alu_op_out          - 0 add, 1 subtract
//   *_wr_out            - register / memory write enables
//   *_reset_out         - register clears, equal to reset_in
//   state_out           - current FSM state, for observation
`timescale 1ns/1ps
module insn_decoder
  import insn_decoder_pkg::*;
#(
  parameter int DATA_WIDTH        = 11,
  parameter int INSTRUCTION_WIDTH = 16
) (
  input  logic                                  clock_in,
  input  logic                                  reset_in,
  input  logic [INSTRUCTION_WIDTH-DATA_WIDTH:0] op_code,
  input  logic                                  status_Z_in,
  input  logic                                  status_N_in,
  output logic                                  branch_out,
  output logic [1:0]                            sel_A_out,
  output logic                                  sel_B_out,
  output logic                                  alu_op_out,
  output logic                                  data_memory_wr_out,
  output logic                                  acc_wr_out,
  output logic                                  pc_wr_out,
  output logic                                  status_wr_out,
  output logic                                  ir_wr_out,
  output logic                                  acc_reset_out,
  output logic                                  pc_reset_out,
  output logic                                  status_reset_out,
  output logic                                  ir_reset_out,
  output state_t                                state_out
);

  state_t state;
  logic [4:0] op5;
  logic       op_unused;

  assign op5       = op_code[4:0];
  assign op_unused = op_code[5];
  assign state_out = state;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state <= ST_FETCH;
    end else begin
      state <= (state == ST_FETCH) ? ST_EXEC : ST_FETCH;
    end
  end

  // Clears follow reset_in directly so they act without a clock edge.
  assign acc_reset_out    = reset_in;
  assign pc_reset_out     = reset_in;
  assign status_reset_out = reset_in;
  assign ir_reset_out     = reset_in;

  // All enables are gated by reset so an EXEC in progress is aborted
  // the moment reset rises, before the state register is even cleared.
  always_comb begin
    branch_out         = 1'b0;
    sel_A_out          = SEL_A_MEM;
    sel_B_out          = 1'b0;
    alu_op_out         = 1'b0;
    data_memory_wr_out = 1'b0;
    acc_wr_out         = 1'b0;
    pc_wr_out          = 1'b0;
    status_wr_out      = 1'b0;
    ir_wr_out          = 1'b0;
    if (!reset_in) begin
      if (state == ST_FETCH) begin
        ir_wr_out = 1'b1;
      end else if (op_unused) begin
        pc_wr_out = 1'b1;
      end else begin
        case (op5)
          OP_HLT: begin
            // PC not advanced: the same HLT is refetched forever.
          end
          OP_STO: begin
            data_memory_wr_out = 1'b1;
            pc_wr_out          = 1'b1;
          end
          OP_LD: begin
            sel_A_out  = SEL_A_MEM;
            acc_wr_out = 1'b1;
            pc_wr_out  = 1'b1;
          end
          OP_LDI: begin
            sel_A_out  = SEL_A_IMM;
            acc_wr_out = 1'b1;
            pc_wr_out  = 1'b1;
          end
          OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
            // op5[0] selects immediate operand, op5[1] selects subtract.
            sel_A_out     = SEL_A_ALU;
            sel_B_out     = op5[0];
            alu_op_out    = op5[1];
            acc_wr_out    = 1'b1;
            status_wr_out = 1'b1;
            pc_wr_out     = 1'b1;
          end
          OP_BEQ: begin branch_out = status_Z_in;                  pc_wr_out = 1'b1; end
          OP_BNE: begin branch_out = !status_Z_in;                 pc_wr_out = 1'b1; end
          OP_BGT: begin branch_out = !status_Z_in && !status_N_in; pc_wr_out = 1'b1; end
          OP_BGE: begin branch_out = !status_N_in;                 pc_wr_out = 1'b1; end
          OP_BLT: begin branch_out = status_N_in;                  pc_wr_out = 1'b1; end
          OP_BLE: begin branch_out = status_Z_in || status_N_in;   pc_wr_out = 1'b1; end
          OP_JMP: begin branch_out = 1'b1;                         pc_wr_out = 1'b1; end
          default: begin
            pc_wr_out = 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_insn_decoder.sv
// tb_insn_decoder
//   Directed bench for insn_decoder. Outputs are packed into one vector
//   {branch, sel_A[1:0], sel_B, alu_op, dmem_wr, acc_wr, pc_wr,
//    status_wr, ir_wr, acc_rst, pc_rst, status_rst, ir_rst}
//   and compared against hand-written constants.
`timescale 1ns/1ps

module clock_generator (
  output logic clk
);
  initial clk = 1'b0;
  always #1 clk = ~clk;
endmodule

module tb_insn_decoder;
  import insn_decoder_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clock_in;
  logic       reset_in;
  logic [5:0] op_code;
  logic       status_Z_in;
  logic       status_N_in;
  logic       branch_out;
  logic [1:0] sel_A_out;
  logic       sel_B_out;
  logic       alu_op_out;
  logic       data_memory_wr_out;
  logic       acc_wr_out;
  logic       pc_wr_out;
  logic       status_wr_out;
  logic       ir_wr_out;
  logic       acc_reset_out;
  logic       pc_reset_out;
  logic       status_reset_out;
  logic       ir_reset_out;
  state_t     state_out;

  clock_generator u_clk (.clk(clock_in));

  insn_decoder #(.DATA_WIDTH(11), .INSTRUCTION_WIDTH(16)) dut (
    .clock_in           (clock_in),
    .reset_in           (reset_in),
    .op_code            (op_code),
    .status_Z_in        (status_Z_in),
    .status_N_in        (status_N_in),
    .branch_out         (branch_out),
    .sel_A_out          (sel_A_out),
    .sel_B_out          (sel_B_out),
    .alu_op_out         (alu_op_out),
    .data_memory_wr_out (data_memory_wr_out),
    .acc_wr_out         (acc_wr_out),
    .pc_wr_out          (pc_wr_out),
    .status_wr_out      (status_wr_out),
    .ir_wr_out          (ir_wr_out),
    .acc_reset_out      (acc_reset_out),
    .pc_reset_out       (pc_reset_out),
    .status_reset_out   (status_reset_out),
    .ir_reset_out       (ir_reset_out),
    .state_out          (state_out)
  );

  logic [13:0] outs;
  assign outs = {branch_out, sel_A_out, sel_B_out, alu_op_out,
                 data_memory_wr_out, acc_wr_out, pc_wr_out, status_wr_out,
                 ir_wr_out, acc_reset_out, pc_reset_out, status_reset_out,
                 ir_reset_out};

  // Expected vectors, field order as in the header.
  localparam logic [13:0] V_RST   = 14'b0_00_0_0_0_0_0_0_0_1111;
  localparam logic [13:0] V_FETCH = 14'b0_00_0_0_0_0_0_0_1_0000;
  localparam logic [13:0] V_HLT   = 14'b0_00_0_0_0_0_0_0_0_0000;
  localparam logic [13:0] V_STO   = 14'b0_00_0_0_1_0_1_0_0_0000;
  localparam logic [13:0] V_LD    = 14'b0_00_0_0_0_1_1_0_0_0000;
  localparam logic [13:0] V_LDI   = 14'b0_01_0_0_0_1_1_0_0_0000;
  localparam logic [13:0] V_ADD   = 14'b0_10_0_0_0_1_1_1_0_0000;
  localparam logic [13:0] V_ADDI  = 14'b0_10_1_0_0_1_1_1_0_0000;
  localparam logic [13:0] V_SUB   = 14'b0_10_0_1_0_1_1_1_0_0000;
  localparam logic [13:0] V_SUBI  = 14'b0_10_1_1_0_1_1_1_0_0000;
  localparam logic [13:0] V_NT    = 14'b0_00_0_0_0_0_1_0_0_0000; // NOP / not taken
  localparam logic [13:0] V_TK    = 14'b1_00_0_0_0_0_1_0_0_0000; // taken

  // ---------------- scoreboard ----------------
  int n_compared;
  int n_mismatched;

  task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %b want %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered at a falling edge while the DUT is in FETCH; leaves the
  // DUT in EXEC, just after the next falling edge.
  task automatic exec_begin(input logic [5:0] op, input logic z, input logic n, input string tag);
    op_code     = op;
    status_Z_in = z;
    status_N_in = n;
    #0.1;
    check({tag, "_fetch"}, outs, V_FETCH);
    @(negedge clock_in);
    #0.1;
  endtask

  task automatic exec_end();
    @(negedge clock_in);
  endtask

  task automatic run_insn(input logic [5:0] op, input logic z, input logic n,
                          input logic [13:0] exp, input string tag);
    exec_begin(op, z, n, tag);
    check(tag, outs, exp);
    exec_end();
  endtask

  // Branch truth table: {op, z, n, taken}
  typedef struct { logic [5:0] op; logic z; logic n; logic tk; string tag; } br_vec_t;
  br_vec_t br_tbl[16];

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    // BGT: !Z&!N
    br_tbl[0]  = '{6'b001010, 1'b0, 1'b0, 1'b1, "bgt_00"};
    br_tbl[1]  = '{6'b001010, 1'b0, 1'b1, 1'b0, "bgt_01"};
    br_tbl[2]  = '{6'b001010, 1'b1, 1'b0, 1'b0, "bgt_10"};
    br_tbl[3]  = '{6'b001010, 1'b1, 1'b1, 1'b0, "bgt_11"};
    // BGE: !N
    br_tbl[4]  = '{6'b001011, 1'b0, 1'b0, 1'b1, "bge_00"};
    br_tbl[5]  = '{6'b001011, 1'b0, 1'b1, 1'b0, "bge_01"};
    br_tbl[6]  = '{6'b001011, 1'b1, 1'b0, 1'b1, "bge_10"};
    br_tbl[7]  = '{6'b001011, 1'b1, 1'b1, 1'b0, "bge_11"};
    // BLT: N
    br_tbl[8]  = '{6'b001100, 1'b0, 1'b0, 1'b0, "blt_00"};
    br_tbl[9]  = '{6'b001100, 1'b0, 1'b1, 1'b1, "blt_01"};
    br_tbl[10] = '{6'b001100, 1'b1, 1'b0, 1'b0, "blt_10"};
    br_tbl[11] = '{6'b001100, 1'b1, 1'b1, 1'b1, "blt_11"};
    // BLE: Z|N
    br_tbl[12] = '{6'b001101, 1'b0, 1'b0, 1'b0, "ble_00"};
    br_tbl[13] = '{6'b001101, 1'b0, 1'b1, 1'b1, "ble_01"};
    br_tbl[14] = '{6'b001101, 1'b1, 1'b0, 1'b1, "ble_10"};
    br_tbl[15] = '{6'b001101, 1'b1, 1'b1, 1'b1, "ble_11"};

    // ---- reset with assorted opcodes ----
    reset_in    = 1'b1;
    op_code     = 6'b000001;
    status_Z_in = 1'b1;
    status_N_in = 1'b1;
    #0.5;
    check("rst_sto", outs, V_RST);
    op_code = 6'b001110;
    #0.2;
    check("rst_jmp", outs, V_RST);
    @(negedge clock_in);
    op_code = 6'(32 + $urandom_range(0, 31));
    #0.1;
    check("rst_rand", outs, V_RST);
    @(negedge clock_in);
    reset_in = 1'b0;

    // ---- release: first FETCH then EXEC; sweep 00000..00111 ----
    run_insn(6'b000000, 1'b0, 1'b0, V_HLT,  "hlt");
    run_insn(6'b000000, 1'b1, 1'b0, V_HLT,  "hlt_again");
    run_insn(6'b000001, 1'b0, 1'b0, V_STO,  "sto");
    run_insn(6'b000010, 1'b0, 1'b0, V_LD,   "ld");
    run_insn(6'b000011, 1'b0, 1'b0, V_LDI,  "ldi");
    run_insn(6'b000100, 1'b0, 1'b0, V_ADD,  "add");
    run_insn(6'b000101, 1'b0, 1'b0, V_ADDI, "addi");
    run_insn(6'b000110, 1'b0, 1'b0, V_SUB,  "sub");
    run_insn(6'b000111, 1'b0, 1'b0, V_SUBI, "subi");

    // ---- BEQ / BNE with Z toggling inside one EXEC ----
    exec_begin(6'b001000, 1'b0, 1'b0, "beq");
    check("beq_z0", outs, V_NT);
    status_Z_in = 1'b1; #0.1;
    check("beq_z1", outs, V_TK);
    status_Z_in = 1'b0; #0.1;
    check("beq_z0b", outs, V_NT);
    exec_end();
    exec_begin(6'b001001, 1'b0, 1'b0, "bne");
    check("bne_z0", outs, V_TK);
    status_Z_in = 1'b1; #0.1;
    check("bne_z1", outs, V_NT);
    status_Z_in = 1'b0; #0.1;
    check("bne_z0b", outs, V_TK);
    exec_end();

    // ---- conditional branches over all flag combinations ----
    foreach (br_tbl[i]) begin
      run_insn(br_tbl[i].op, br_tbl[i].z, br_tbl[i].n,
               br_tbl[i].tk ? V_TK : V_NT, br_tbl[i].tag);
    end

    // ---- JMP with every flag combination ----
    for (int k = 0; k < 4; k++) begin
      run_insn(6'b001110, k[1], k[0], V_TK, $sformatf("jmp_%0d", k));
    end

    // ---- unused opcodes decode as NOP ----
    run_insn(6'b001111, 1'b1, 1'b1, V_NT, "nop_0f");
    run_insn(6'b011111, 1'b0, 1'b1, V_NT, "nop_1f");
    run_insn(6'b100001, 1'b0, 1'b0, V_NT, "nop_b5_sto");
    run_insn(6'b101000, 1'b1, 1'b0, V_NT, "nop_b5_beq");

    // ---- reset mid-EXEC of STO aborts immediately ----
    exec_begin(6'b000001, 1'b0, 1'b0, "sto_abort");
    check("sto_abort_exec", outs, V_STO);
    #0.2;
    reset_in = 1'b1;
    #0.1;
    check("sto_abort_rst", outs, V_RST);
    @(negedge clock_in);
    #0.1;
    check("sto_abort_hold", outs, V_RST);
    @(negedge clock_in);
    reset_in = 1'b0;
    // Restart: FETCH then EXEC regardless of where reset hit.
    run_insn(6'b000011, 1'b0, 1'b0, V_LDI, "post_rst_ldi");
    run_insn(6'b000001, 1'b0, 1'b0, V_STO, "post_rst_sto");

    // ---- final report ----
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
